// File: rtl/input_char_pkg.sv
// Shared constants for the console input device and its sibling display device.
package input_char_pkg;

  localparam int ST_AVAIL = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Carriage returns from the host become line feeds so the CPU sees one line terminator.
  function automatic logic [7:0] rx_translate(input logic [7:0] c, input bit cr_to_lf);
    return (cr_to_lf && (c == CHAR_CR)) ? CHAR_LF : c;
  endfunction

endpackage

// File: rtl/input_char_if.sv
// Bus and host-link signals of the console input device.
interface input_char_if;

  wire  [7:0] main_bus;
  logic [7:0] bus_drv;
  logic       bus_oe;
  logic       out_val;
  logic       out_status;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       data_avail;

  // The device only supplies drive value and enable; the tri-state resolves here on the shared bus.
  assign main_bus = bus_oe ? bus_drv : 8'bz;

  modport master (
    inout  main_bus,
    input  bus_oe,
    output out_val,
    output out_status,
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  data_avail
  );

  modport slave (
    output bus_drv,
    output bus_oe,
    input  out_val,
    input  out_status,
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output data_avail
  );

endinterface

// File: rtl/input_char_sync_fifo.sv
// Synchronous FIFO with combinational head data; DEPTH must be a power of two.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/input_char.sv
// Console input device: buffers host bytes and lets the CPU read data or status onto main_bus.
module input_char
  import input_char_pkg::*;
#(
  parameter int         DEPTH      = 8,
  parameter bit         CR_TO_LF   = 1'b1,
  parameter logic [7:0] EMPTY_CHAR = 8'h00
) (
  input  logic         clk,
  input  logic         rst_n,
  input_char_if.slave  bus
);

  logic [7:0]               head;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     push;
  logic                     ovf;
  logic                     ovf_set;
  logic [7:0]               status;

  assign bus.rx_ready   = !full || bus.out_val;
  assign bus.data_avail = (count != '0);
  assign push           = bus.rx_valid && bus.rx_ready;

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (bus.out_val),
    .wr_data (rx_translate(bus.rx_data, CR_TO_LF)),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Overflow is diagnostic only: the host pushed while full and no pop could make room.
  assign ovf_set = bus.rx_valid && full && !bus.out_val;

  always_ff @(posedge clk) begin
    if (!rst_n)              ovf <= 1'b0;
    else if (ovf_set)        ovf <= 1'b1;
    else if (bus.out_status) ovf <= 1'b0;
  end

  always_comb begin
    status           = '0;
    status[ST_AVAIL] = bus.data_avail;
    status[ST_FULL]  = full;
    status[ST_OVF]   = ovf;
  end

  // Data read wins the bus if both strobes are (illegally) raised together.
  always_comb begin
    bus.bus_drv = EMPTY_CHAR;
    bus.bus_oe  = 1'b0;
    if (bus.out_val) begin
      bus.bus_oe  = 1'b1;
      bus.bus_drv = empty ? EMPTY_CHAR : head;
    end else if (bus.out_status) begin
      bus.bus_oe  = 1'b1;
      bus.bus_drv = status;
    end
  end

endmodule

// File: tb/tb_input_char.sv
// Scoreboard bench: two devices (CR translation on and off) share stimulus and one queue-based model.
module tb_input_char;

  localparam int DEPTH = 8;

  typedef struct packed {
    bit         oe;
    logic [7:0] bus0;
    logic [7:0] bus1;
    bit         ready;
    bit         avail;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  input_char_if if0 ();
  input_char_if if1 ();

  assign if1.out_val    = if0.out_val;
  assign if1.out_status = if0.out_status;
  assign if1.rx_data    = if0.rx_data;
  assign if1.rx_valid   = if0.rx_valid;

  input_char #(.DEPTH(DEPTH), .CR_TO_LF(1'b1), .EMPTY_CHAR(8'h00)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  input_char #(.DEPTH(DEPTH), .CR_TO_LF(1'b0), .EMPTY_CHAR(8'h00)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  exp_t       sb[$];
  logic [7:0] model_q[$];
  bit         model_ovf;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue what both devices should show, then step the model.
  task automatic applyStimulus(input bit rst, input bit v, input logic [7:0] d,
                               input bit ov, input bit os);
    exp_t e;
    int   sz = model_q.size();
    bit   is_full = (sz == DEPTH);
    rst_n          = rst;
    if0.rx_valid   = v;
    if0.rx_data    = d;
    if0.out_val    = ov;
    if0.out_status = os;
    e.ready = !is_full || ov;
    e.avail = (sz != 0);
    e.oe    = ov || os;
    e.bus0  = 8'h00;
    e.bus1  = 8'h00;
    if (ov) begin
      if (sz > 0) begin
        e.bus0 = (model_q[0] == 8'h0D) ? 8'h0A : model_q[0];
        e.bus1 = model_q[0];
      end
    end else if (os) begin
      e.bus0 = {5'b0, model_ovf, is_full, sz != 0};
      e.bus1 = e.bus0;
    end
    sb.push_back(e);
    if (!rst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (v && is_full && !ov) model_ovf = 1'b1;
      else if (os)             model_ovf = 1'b0;
      if (ov && sz > 0) void'(model_q.pop_front());
      if (v && e.ready) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("oe0", {7'b0, if0.bus_oe}, {7'b0, e.oe});
        checkOutput("oe1", {7'b0, if1.bus_oe}, {7'b0, e.oe});
        if (e.oe) begin
          checkOutput("bus0", if0.main_bus, e.bus0);
          checkOutput("bus1", if1.main_bus, e.bus1);
        end
        checkOutput("ready0", {7'b0, if0.rx_ready},   {7'b0, e.ready});
        checkOutput("ready1", {7'b0, if1.rx_ready},   {7'b0, e.ready});
        checkOutput("avail0", {7'b0, if0.data_avail}, {7'b0, e.avail});
        checkOutput("avail1", {7'b0, if1.data_avail}, {7'b0, e.avail});
      end
    end
  end

  initial begin : stimulus
    int waited;
    rst_n          = 1'b0;
    if0.rx_valid   = 1'b0;
    if0.rx_data    = 8'h00;
    if0.out_val    = 1'b0;
    if0.out_status = 1'b0;
    model_ovf      = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    applyStimulus(1, 0, 8'h00, 0, 0);
    applyStimulus(1, 1, 8'h41, 0, 0);
    applyStimulus(1, 0, 8'h00, 1, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);

    applyStimulus(1, 1, 8'h0D, 0, 0);
    applyStimulus(1, 0, 8'h00, 1, 0);

    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, 8'(8'h30 + i), 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 1);
    applyStimulus(1, 1, 8'h38, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 1);
    applyStimulus(1, 0, 8'h00, 0, 1);

    applyStimulus(1, 1, 8'h38, 1, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 8'h00, 1, 0);
    applyStimulus(1, 0, 8'h00, 1, 0);
    applyStimulus(1, 1, 8'h5A, 0, 0);
    applyStimulus(1, 0, 8'h00, 1, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);

    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 8'(8'h61 + i), 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 1);
    applyStimulus(1, 0, 8'h00, 1, 0);

    for (int i = 0; i < 600; i++) begin
      bit         r  = ($urandom_range(99) >= 2);
      bit         v  = ($urandom_range(99) < 55);
      bit         ov = ($urandom_range(99) < 30);
      bit         os = ($urandom_range(99) < 15);
      logic [7:0] d  = ($urandom_range(9) == 0) ? 8'h0D : 8'($urandom);
      applyStimulus(r, v, d, ov, os);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
